// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between instruction fetch and data
//            requesters with alternating tie-break and timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_mask,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [9:0] C_TIMEOUT = 10'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_gnt;       // 0 = instruction, 1 = data
    logic        r_last;      // last requester that received a response
    logic [9:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic        r_we;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_if_err;
    logic        r_d_err;

    logic        w_any_req;
    logic        w_pick_d;
    logic        w_expired;

    // Data wins when it is alone, or on a tie when instruction was served last
    // (or nothing yet, since last resets to instruction).
    assign w_any_req = if_req | d_req;
    assign w_pick_d  = d_req & (~if_req | ~r_last);
    assign w_expired = (r_cnt == C_TIMEOUT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; an ack on the expiry cycle still counts
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        if_valid    = 1'b0;
        d_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_req = ~w_expired;
                if (mem_ack || w_expired) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if_valid    = ~r_gnt;
                d_valid     = r_gnt;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant capture, request field latching and BUSY cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt   <= 1'b0;
            r_cnt   <= 10'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
            r_we    <= 1'b0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_gnt <= w_pick_d;
            r_cnt <= 10'd0;
            if (w_pick_d) begin
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                r_mask  <= d_mask;
                r_we    <= d_we;
            end else begin
                r_addr  <= if_addr;
                r_wdata <= 32'd0;
                r_mask  <= 4'hF;
                r_we    <= 1'b0;
            end
        end else if (r_state == ST_BUSY && !mem_ack && !w_expired) begin
            r_cnt <= r_cnt + 10'd1;
        end
    end

    // Response data/error capture and tie-break history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last     <= 1'b0;
            r_if_rdata <= 32'd0;
            r_d_rdata  <= 32'd0;
            r_if_err   <= 1'b0;
            r_d_err    <= 1'b0;
        end else if (r_state == ST_BUSY && (mem_ack || w_expired)) begin
            r_last <= r_gnt;
            if (r_gnt) begin
                r_d_rdata <= mem_ack ? mem_rdata : 32'd0;
                r_d_err   <= ~mem_ack;
            end else begin
                r_if_rdata <= mem_ack ? mem_rdata : 32'd0;
                r_if_err   <= ~mem_ack;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_mask  = r_mask;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter; transaction-level model of
//            grant choice, memory port contents, latency and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int C_TIMEOUT = 10;
    localparam int C_NOACK   = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_mask = 4'd0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(C_TIMEOUT)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_mask    (d_mask),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_mask  (mem_mask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: who was served last, and each requester's
    // most recent response word and error flag (index 0 = fetch, 1 = data).
    bit          m_last;
    logic [31:0] m_rdata [2];
    bit          m_err   [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last     = 1'b0;
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;
        m_err[0]   = 1'b0;
        m_err[1]   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_mem_req"},   32'(mem_req),   32'd0);
        check_eq({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check_eq({tag, "_mem_mask"},  32'(mem_mask),  32'd0);
        check_eq({tag, "_mem_addr"},  mem_addr,       32'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check_eq({tag, "_rdata"},     if_rdata | d_rdata, 32'd0);
        check_eq({tag, "_valid"},     32'({if_valid, d_valid}), 32'd0);
        check_eq({tag, "_err"},       32'({if_err, d_err}),     32'd0);
    endtask

    task automatic scramble_requesters();
        if_req  = 1'($urandom);
        d_req   = 1'($urandom);
        d_we    = 1'($urandom);
        d_mask  = 4'($urandom);
        if_addr = $urandom;
        d_addr  = $urandom;
        d_wdata = $urandom;
    endtask

    // One arbitration round, entered and left at the falling edge of an IDLE
    // cycle. lat = number of BUSY cycles before the ack cycle (0 = 1-cycle
    // memory); lat > C_TIMEOUT means memory never answers.
    task automatic txn(input bit ri, input bit rd, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] dw,
                       input logic [3:0] dm, input bit dwe, input int lat,
                       input logic [31:0] ack_data, input bit churn, input bit hold);
        bit          g;
        bit          acked;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        bit          e_we;

        check_eq("idle_mem_req", 32'(mem_req), 32'd0);
        check_eq("idle_valid",   32'({if_valid, d_valid}), 32'd0);
        check_eq("hold_if_rdata", if_rdata, m_rdata[0]);
        check_eq("hold_d_rdata",  d_rdata,  m_rdata[1]);
        check_eq("hold_err",      32'({if_err, d_err}), 32'({m_err[0], m_err[1]}));

        if_req = ri; d_req = rd; if_addr = ia; d_addr = da;
        d_wdata = dw; d_mask = dm; d_we = dwe;

        if (!ri && !rd) begin
            @(posedge clk);
            @(negedge clk);
            return;
        end

        g = rd && (!ri || !m_last);
        if (g) begin
            e_addr = da; e_wdata = dw; e_mask = dm; e_we = dwe;
        end else begin
            e_addr = ia; e_wdata = 32'd0; e_mask = 4'hF; e_we = 1'b0;
        end

        @(posedge clk);
        acked = 1'b0;
        for (int k = 0; k <= C_TIMEOUT; k++) begin
            @(negedge clk);
            if (churn) scramble_requesters();
            check_eq("busy_mem_req",   32'(mem_req),  32'(k < C_TIMEOUT));
            check_eq("busy_mem_addr",  mem_addr,      e_addr);
            check_eq("busy_mem_we",    32'(mem_we),   32'(e_we));
            check_eq("busy_mem_mask",  32'(mem_mask), 32'(e_mask));
            check_eq("busy_mem_wdata", mem_wdata,     e_wdata);
            check_eq("busy_no_valid",  32'({if_valid, d_valid}), 32'd0);
            mem_ack   = (k == lat);
            mem_rdata = (k == lat) ? ack_data : $urandom;
            @(posedge clk);
            if (k == lat) begin
                acked = 1'b1;
                break;
            end
        end

        m_rdata[g] = acked ? ack_data : 32'd0;
        m_err[g]   = !acked;
        m_last     = g;

        @(negedge clk);
        check_eq("resp_if_valid", 32'(if_valid), 32'(!g));
        check_eq("resp_d_valid",  32'(d_valid),  32'(g));
        check_eq("resp_if_rdata", if_rdata, m_rdata[0]);
        check_eq("resp_d_rdata",  d_rdata,  m_rdata[1]);
        check_eq("resp_if_err",   32'(if_err), 32'(m_err[0]));
        check_eq("resp_d_err",    32'(d_err),  32'(m_err[1]));
        check_eq("resp_mem_req",  32'(mem_req), 32'd0);
        // Stray ack during RESP and the following IDLE cycle must be ignored.
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        if (!hold) begin
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic random_txn();
        int          sel;
        int          lat;
        logic [1:0]  rq;
        rq  = 2'($urandom);
        sel = $urandom_range(0, 99);
        if (sel < 50)      lat = $urandom_range(0, 2);
        else if (sel < 70) lat = $urandom_range(3, C_TIMEOUT - 1);
        else if (sel < 80) lat = C_TIMEOUT;
        else               lat = C_NOACK;
        txn(rq[0], rq[1], $urandom, $urandom, $urandom, 4'($urandom),
            1'($urandom), lat, $urandom, 1'($urandom), 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Both requesters held from reset: grants must go D, I, D, I.
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b1, 32'h0000_1000, 32'h0000_8000, 32'h1111_2222,
                4'hC, 1'b1, 0, 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
        end

        // Single fetch with 1-cycle memory.
        txn(1'b1, 1'b0, 32'h0000_0100, 32'd0, 32'd0, 4'd0, 1'b0, 0,
            32'h0050_0093, 1'b0, 1'b0);
        // Store whose requester inputs churn during BUSY.
        txn(1'b0, 1'b1, 32'd0, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1,
            32'h5555_AAAA, 1'b1, 1'b0);
        // Ack after 7 extra cycles: mem_req high for 8 cycles.
        txn(1'b0, 1'b1, 32'd0, 32'h0000_3000, 32'd0, 4'hF, 1'b0, 7,
            32'h1234_5678, 1'b0, 1'b0);
        // Data load that times out, then one that is acked on the expiry cycle.
        txn(1'b0, 1'b1, 32'd0, 32'h0000_4000, 32'd0, 4'hF, 1'b0, C_NOACK,
            32'h0, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 32'h0000_0200, 32'd0, 32'd0, 4'd0, 1'b0, C_TIMEOUT,
            32'hCAFE_F00D, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            random_txn();
        end

        // Asynchronous reset while BUSY, with a late ack afterwards.
        mem_ack = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b0;
        if_addr = 32'h0000_0400;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_pre_mem_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        if_req  = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_late_ack_valid",   32'({if_valid, d_valid}), 32'd0);
        check_eq("rst_late_ack_mem_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        @(negedge clk);

        txn(1'b1, 1'b0, 32'h0000_0500, 32'd0, 32'd0, 4'd0, 1'b0, 0,
            32'h0010_0113, 1'b0, 1'b0);
        // After reset last is instruction again, so data wins the tie.
        txn(1'b1, 1'b1, 32'h0000_0600, 32'h0000_9000, 32'h7777_8888, 4'h1,
            1'b1, 2, 32'h0BAD_F00D, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single unified memory port between the core's instruction-fetch requester and its data (load/store) requester. Each requester issues a level request; the arbiter grants one at a time, drives the memory port from latched request fields, returns read data with a one-cycle valid pulse, and aborts transactions that exceed a timeout. It sits between the core's fetch/memory stages and the external memory.

## Interface
- TIMEOUT, 255: maximum BUSY cycles without `mem_ack` before abort (1..1023).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  instruction fetch request (level).
- if_addr  input  32  fetch address.
- if_rdata  output  32  fetched word.
- if_valid  output  1  one-cycle response pulse for fetch.
- if_err  output  1  fetch aborted by timeout (qualified by `if_valid`).
- d_req  input  1  data request (level).
- d_we  input  1  1 = store, 0 = load.
- d_mask  input  4  byte-enable mask.
- d_addr  input  32  data address.
- d_wdata  input  32  store data.
- d_rdata  output  32  load data.
- d_valid  output  1  one-cycle response pulse for data.
- d_err  output  1  data access aborted by timeout (qualified by `d_valid`).
- mem_req  output  1  memory request, held until ack or abort.
- mem_we  output  1  memory write enable.
- mem_mask  output  4  memory byte enables.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, valid with `mem_ack`.
- mem_ack  input  1  one-cycle completion from memory.

## Operation
- FSM states: IDLE, BUSY, RESP. A `gnt` bit (0 = instruction, 1 = data) and a `last` bit (last granted requester) are kept.
- IDLE: if exactly one request is high, grant it. If both are high, grant the requester that is not `last`. Latch the address, mask, we and wdata, then go to BUSY. With no request, stay in IDLE.
- Instruction grant: `mem_we=0`, `mem_mask=4'hF`, `mem_wdata=0`.
- Data grant: `mem_we=d_we`, `mem_mask=d_mask`, `mem_wdata=d_wdata`, all from latched copies.
- BUSY:
  - `mem_req=1`, and all `mem_*` outputs are driven from the latched registers.
  - The requester inputs may change freely without effect.
  - On `mem_ack`: capture `mem_rdata` into the granted requester's rdata register, clear err, set `last=gnt`, and go to RESP.
- Timeout: a 10-bit counter clears on entry to BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT:
  - drop `mem_req`;
  - load rdata with 0 and set the granted requester's err to 1;
  - set `last=gnt` and go to RESP.
- RESP: pulse the granted requester's valid for exactly one cycle, then go to IDLE. No arbitration happens in RESP. The requester must drop req at the edge that ends its valid cycle, or a new transaction is started.
- `mem_ack` in IDLE or RESP is ignored. An ack in the same cycle the timeout is reached wins: the transaction completes normally, err=0.
- Store responses also capture `mem_rdata`; the value is don't-care for the core.
- rdata and err registers hold their values until the next response to the same requester.

## Timing
- Reset (asynchronous, `rst=0`):
  - state=IDLE, `last=0` (instruction), counter=0.
  - All outputs are 0: `mem_req`, `mem_we`, `mem_mask`, `mem_addr`, `mem_wdata`, both rdata, both valid, both err.
- Reset mid-transaction: `mem_req` drops immediately, the transaction is discarded, no valid is issued, and a late ack is ignored.
- Minimum latency with 1-cycle memory:
  - req seen in IDLE at cycle 0;
  - cycle 1 BUSY with `mem_req=1`, ack arrives;
  - cycle 2 RESP with valid=1;
  - cycle 3 IDLE, next arbitration.
- Throughput: one transaction per 3 cycles at best.
- Timeout abort: valid is asserted TIMEOUT+1 cycles after BUSY entry.
- Tie after reset: `last=0`, so data wins the first simultaneous request.

## Test plan
- Single fetch: `if_req=1`, `if_addr=0x100`, memory acks 1 cycle later with 0x00500093 -> `mem_addr=0x100`, `mem_we=0`, `mem_mask=4'hF`; `if_valid` pulses at cycle 2 with `if_rdata=0x00500093`, `if_err=0`.
- Store: `d_req=1`, `d_we=1`, `d_addr=0x2004`, `d_mask=4'b0011`, `d_wdata=0xDEADBEEF` -> memory sees the same address/mask/data with `mem_we=1`; `d_valid` pulses once; the inputs are changed during BUSY and `mem_*` does not change.
- Contention: both requests held continuously from reset -> grants alternate D, I, D, I; each valid is a single-cycle pulse.
- Variable latency: ack delayed 7 cycles -> `mem_req` stays high for 8 cycles; valid occurs the cycle after ack.
- Timeout with TIMEOUT=4 and no ack -> `mem_req` drops after 4 BUSY cycles; `d_valid=1`, `d_err=1`, `d_rdata=0`; a subsequent spurious ack is ignored.
- Async reset in BUSY -> `mem_req=0` immediately, no valid; after release, a new fetch completes normally.
